move_cmd_gen: RTL and testbench

Converts the five raw board push-buttons into the clean single-cycle command strobes that drive the player position block: `up`/`left`/`right`/`down` move pulses, a `pause` level and a `reset_player` pulse. Sits between the board pins and the player logic in the game top level. Each button passes through a two-flop synchroniser, a debouncer and an edge detector. A centre-button state machine separates a short press (pause toggle) from a long press (player reset).

---
 rtl/move_cmd_gen.sv | 208 ++++++++++++++++++++
 tb/tb_move_cmd_gen.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/move_cmd_gen.sv
// move_cmd_gen: synchronise, debounce and edge-detect the five board buttons into
// move strobes, a pause level and a reset_player pulse. Optional macro: AUTO_REPEAT_EN.
module move_cmd_gen #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int HOLD_CYCLES     = 100000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 25000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_up,
    input  logic btn_left,
    input  logic btn_right,
    input  logic btn_down,
    input  logic btn_center,
    output logic up,
    output logic left,
    output logic right,
    output logic down,
    output logic pause,
    output logic reset_player
);

    localparam int MAX_A = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
    localparam int MAX_B = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW    = $clog2(MAX_P + 1);

    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t DEB_LAST  = cnt_t'(DEBOUNCE_CYCLES - 1);
    localparam cnt_t HOLD_LAST = cnt_t'(HOLD_CYCLES - 1);
    localparam cnt_t CNT_ONE   = cnt_t'(1);

    // Button bit order: 0 up, 1 left, 2 right, 3 down, 4 centre (bit 0 wins priority).
    localparam int B_CENTER = 4;

    typedef enum logic [1:0] {
        C_IDLE,
        C_PRESSED,
        C_LONG
    } c_state_t;

    logic [4:0] btn_raw;
    logic [4:0] sync1_q, sync2_q;
    logic [4:0] deb_q, deb_d, deb_prev_q;
    cnt_t       deb_cnt_q [5];
    cnt_t       deb_cnt_d [5];

    c_state_t   c_state_q, c_state_d;
    cnt_t       hold_cnt_q, hold_cnt_d;
    logic       pause_q, pause_d;
    logic       reset_player_q, reset_player_d;
    logic       c_rise;

    logic [3:0] dir_edge, rep_req, dir_sel_d, dir_q;

    function automatic logic [3:0] pick_first(input logic [3:0] v);
        return v & (~v + 4'd1);
    endfunction

    assign btn_raw = {btn_center, btn_down, btn_right, btn_left, btn_up};

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        deb_d = deb_q;
        for (int i = 0; i < 5; i++) begin
            deb_cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (deb_cnt_q[i] == DEB_LAST) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            // NOTE: the counter array is cleared explicitly; a held button must restart its debounce after reset.
            for (int i = 0; i < 5; i++) begin
                deb_cnt_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge value of its source.
            sync1_q    <= btn_raw;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            for (int i = 0; i < 5; i++) begin
                deb_cnt_q[i] <= deb_cnt_d[i];
            end
        end
    end

    assign c_rise = deb_q[B_CENTER] & ~deb_prev_q[B_CENTER];

    always_comb begin
        c_state_d      = c_state_q;
        hold_cnt_d     = hold_cnt_q;
        pause_d        = pause_q;
        reset_player_d = 1'b0;
        unique case (c_state_q)
            C_IDLE: begin
                if (c_rise) begin
                    c_state_d  = C_PRESSED;
                    hold_cnt_d = '0;
                end
            end
            C_PRESSED: begin
                if (!deb_q[B_CENTER]) begin
                    pause_d   = ~pause_q;
                    c_state_d = C_IDLE;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    reset_player_d = 1'b1;
                    pause_d        = 1'b0;
                    c_state_d      = C_LONG;
                end else begin
                    hold_cnt_d = hold_cnt_q + CNT_ONE;
                end
            end
            C_LONG: begin
                if (!deb_q[B_CENTER]) begin
                    c_state_d = C_IDLE;
                end
            end
            default: c_state_d = C_IDLE;
        endcase
    end

    // Suppression uses the registered pause, so a same-cycle force-to-0 cannot release a strobe.
    assign dir_edge  = deb_q[3:0] & ~deb_prev_q[3:0];
    assign dir_sel_d = pause_q ? 4'b0 : pick_first(dir_edge | rep_req);

`ifdef AUTO_REPEAT_EN
    localparam cnt_t DELAY_LAST  = cnt_t'(REPEAT_DELAY - 1);
    localparam cnt_t PERIOD_LAST = cnt_t'(REPEAT_PERIOD - 1);

    logic [3:0] top_held, rep_dir_q, rep_dir_d;
    logic       rep_first_q, rep_first_d, rep_fire;
    cnt_t       rep_cnt_q, rep_cnt_d;

    // Only the highest-priority held direction owns the repeat timer.
    assign top_held = pick_first(deb_q[3:0]);
    assign rep_fire = (rep_dir_q != 4'b0) && (rep_dir_q == top_held) &&
                      (rep_cnt_q == (rep_first_q ? DELAY_LAST : PERIOD_LAST));
    assign rep_req  = rep_fire ? rep_dir_q : 4'b0;

    always_comb begin
        rep_dir_d   = rep_dir_q;
        rep_first_d = rep_first_q;
        rep_cnt_d   = rep_cnt_q + CNT_ONE;
        if (pause_q || rep_dir_q == 4'b0 || rep_dir_q != top_held) begin
            rep_dir_d   = 4'b0;
            rep_first_d = 1'b1;
            rep_cnt_d   = '0;
        end
        if (dir_sel_d != 4'b0 && dir_sel_d == top_held) begin
            rep_dir_d   = dir_sel_d;
            rep_first_d = ~rep_fire;
            rep_cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_dir_q   <= 4'b0;
            rep_first_q <= 1'b1;
            rep_cnt_q   <= '0;
        end else begin
            rep_dir_q   <= rep_dir_d;
            rep_first_q <= rep_first_d;
            rep_cnt_q   <= rep_cnt_d;
        end
    end
`else
    assign rep_req = 4'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_state_q      <= C_IDLE;
            hold_cnt_q     <= '0;
            pause_q        <= 1'b0;
            reset_player_q <= 1'b0;
            dir_q          <= 4'b0;
        end else begin
            c_state_q      <= c_state_d;
            hold_cnt_q     <= hold_cnt_d;
            pause_q        <= pause_d;
            reset_player_q <= reset_player_d;
            dir_q          <= dir_sel_d;
        end
    end

    assign up           = dir_q[0];
    assign left         = dir_q[1];
    assign right        = dir_q[2];
    assign down         = dir_q[3];
    assign pause        = pause_q;
    assign reset_player = reset_player_q;

endmodule

// File: tb/tb_move_cmd_gen.sv
// Bench for move_cmd_gen: table of button vectors plus hand sequences; expected strobes
// are queued with their cycle number and matched by a negedge monitor.
module tb_move_cmd_gen;

    logic clk = 1'b0;
    logic rst_n;
    logic btn_up, btn_left, btn_right, btn_down, btn_center;
    logic up, left, right, down, pause, reset_player;

    move_cmd_gen #(
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES    (20),
        .REPEAT_DELAY   (10),
        .REPEAT_PERIOD  (5)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_up      (btn_up),
        .btn_left    (btn_left),
        .btn_right   (btn_right),
        .btn_down    (btn_down),
        .btn_center  (btn_center),
        .up          (up),
        .left        (left),
        .right       (right),
        .down        (down),
        .pause       (pause),
        .reset_player(reset_player)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observed word: {reset_player, down, right, left, up}
    typedef struct {
        int         cyc;
        logic [4:0] val;
    } exp_t;

    typedef struct {
        string      name;
        logic [4:0] btns;   // {center, down, right, left, up}
        int         hold;
        logic [4:0] exp;
    } vec_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic push_exp(input int c, input logic [4:0] v);
        exp_t e;
        e.cyc = c;
        e.val = v;
        sb_q.push_back(e);
    endtask

    task automatic drain(input string name);
        check(name, sb_q.size(), 0);
        sb_q.delete();
    endtask

    task automatic set_btns(input logic [4:0] b);
        {btn_center, btn_down, btn_right, btn_left, btn_up} = b;
    endtask

    // Centre held 5 cycles: debounced fall lands 11 edges after the press, pause flips on the 12th.
    task automatic short_press(input logic exp_pause);
        int c;
        c = cyc;
        btn_center = 1'b1;
        wait_cycles(5);
        btn_center = 1'b0;
        wait_until(c + 11);
        check("pause_before_toggle", pause, !exp_pause);
        wait_until(c + 12);
        check("pause_toggle", pause, exp_pause);
        wait_cycles(10);
    endtask

    logic [4:0] obs;
    always @(negedge clk) begin
        exp_t e;
        obs = {reset_player, down, right, left, up};
        if (obs != 5'b0) begin
            if (sb_q.size() == 0) begin
                check("unexpected_strobe", obs, 5'b0);
            end else begin
                e = sb_q.pop_front();
                check("strobe_cycle", cyc, e.cyc);
                check("strobe_value", obs, e.val);
            end
        end
    end

    vec_t vecs[8];

    initial begin
        int c;
        int r;

        vecs[0] = '{"right_clean",    5'b00100, 10, 5'b00100};
        vecs[1] = '{"right_repress",  5'b00100, 10, 5'b00100};
        vecs[2] = '{"left_down_same", 5'b01010, 10, 5'b00010};
        vecs[3] = '{"all_dirs",       5'b01111, 10, 5'b00001};
        vecs[4] = '{"down_only",      5'b01000, 10, 5'b01000};
        vecs[5] = '{"up_min_hold",    5'b00001,  4, 5'b00001};
        vecs[6] = '{"up_too_short",   5'b00001,  3, 5'b00000};
        vecs[7] = '{"right_down",     5'b01100, 10, 5'b00100};

        rst_n = 1'b0;
        set_btns(5'b0);
        wait_cycles(3);
        check("reset_outputs", {reset_player, pause, down, right, left, up}, 6'b0);
        rst_n = 1'b1;
        wait_cycles(5);

        for (int i = 0; i < 8; i++) begin
            c = cyc;
            set_btns(vecs[i].btns);
            if (vecs[i].exp != 5'b0) push_exp(c + 7, vecs[i].exp);
            wait_cycles(vecs[i].hold);
            set_btns(5'b0);
            wait_cycles(20);
            drain({vecs[i].name, "_drain"});
        end

        // Bounce: 2-cycle toggles never survive debounce; the final stable rise strobes 7 later.
        for (int i = 0; i < 20; i++) begin
            btn_up = ((i / 2) % 2 == 0);
            @(negedge clk);
        end
        c = cyc;
        btn_up = 1'b1;
        push_exp(c + 7, 5'b00001);
        wait_cycles(10);
        btn_up = 1'b0;
        wait_cycles(20);
        drain("bounce_drain");

        // Pause on, up press swallowed, pause off.
        short_press(1'b1);
        btn_up = 1'b1;
        wait_cycles(10);
        btn_up = 1'b0;
        wait_cycles(20);
        drain("paused_up_drain");
        short_press(1'b0);

        // Long press from pause=1: reset_player at press+27, pause forced low, no toggle on release.
        short_press(1'b1);
        c = cyc;
        btn_center = 1'b1;
        push_exp(c + 27, 5'b10000);
        wait_until(c + 26);
        check("long_pause_held", pause, 1'b1);
        wait_until(c + 27);
        check("long_pause_forced", pause, 1'b0);
        wait_until(c + 40);
        btn_center = 1'b0;
        wait_cycles(25);
        check("long_release_no_toggle", pause, 1'b0);
        drain("long_drain");

        // Reset while down is mid-debounce (counter at 2) and pause is set.
        short_press(1'b1);
        c = cyc;
        btn_down = 1'b1;
        wait_until(c + 4);
        rst_n = 1'b0;
        #1;
        check("midreset_outputs", {reset_player, pause, down, right, left, up}, 6'b0);
        wait_cycles(3);
        r = cyc;
        rst_n = 1'b1;
        push_exp(r + 7, 5'b01000);
        wait_cycles(20);
        btn_down = 1'b0;
        wait_cycles(20);
        drain("midreset_drain");
        check("midreset_pause", pause, 1'b0);

`ifdef AUTO_REPEAT_EN
        c = cyc;
        btn_left = 1'b1;
        push_exp(c + 7,  5'b00010);
        push_exp(c + 17, 5'b00010);
        push_exp(c + 22, 5'b00010);
        push_exp(c + 27, 5'b00010);
        push_exp(c + 32, 5'b00010);
        push_exp(c + 37, 5'b00010);
        wait_cycles(35);
        btn_left = 1'b0;
        wait_cycles(25);
        drain("repeat_drain");
`endif

        wait_cycles(5);
        drain("final_drain");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
